// File: rtl/rv_pkg.sv
// Shared core types used by the load/store path: access size, LSU state,
// registered request payload and the size-to-byte-count helper.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2
  } mem_op_sz_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    mem_op_sz_e      size;
    logic            uns;
  } lsu_req_t;

  // 0 marks an encoding that is not a legal access size
  function automatic logic [2:0] mem_op_bytes(mem_op_sz_e sz);
    logic [2:0] n;
    case (sz)
      BYTE:    n = 3'd1;
      HWORD:   n = 3'd2;
      WORD:    n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshakes and data-memory strobes of the load/store controller.
// The slave modport is the controller's view; master is the execute stage + memory side.
interface lsu_ctrl_if;
  import rv_pkg::*;

  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [XLEN-1:0]   i_req_addr;
  logic [XLEN-1:0]   i_req_wdata;
  mem_op_sz_e        i_req_size;
  logic              i_req_unsigned;

  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [XLEN-1:0]   o_rsp_rdata;
  logic              o_rsp_err;

  logic              o_mem_we;
  logic              o_mem_re;
  logic [XLEN-1:0]   o_mem_addr;
  logic [XLEN-1:0]   o_mem_wdata;
  mem_op_sz_e        o_mem_size;
  logic [XLEN-1:0]   i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
    input  i_rsp_ready, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata, o_mem_size
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
    output i_rsp_ready, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata, o_mem_size
  );

endinterface

// File: rtl/lsu_ctrl_load_extend.sv
// Sign/zero extension of LSB-aligned load data to the full register width.
module load_extend
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  mem_op_sz_e      size_i,
  input  logic            uns_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      BYTE:    data_o = {{24{data_i[7]  & ~uns_i}}, data_i[7:0]};
      HWORD:   data_o = {{16{data_i[15] & ~uns_i}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of the byte-addressed data memory.
// LSU_MISALIGN_SPLIT_EN: misaligned in-range accesses become a sequence of byte accesses.
module lsu_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned MemoryBytesSize = 'h4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  lsu_ctrl_if.slave  bus
);

  localparam logic [XLEN:0] LimitBytes = (XLEN+1)'(MemoryBytesSize * 4);

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [2:0]      req_bytes;
  logic [XLEN:0]   addr_end;
  logic            misaligned, illegal, out_of_range, req_err;
  logic [XLEN-1:0] ext_in, ext_data;

  // Request check; the end address is formed one bit wider so it cannot wrap
  always_comb begin
    req_bytes    = mem_op_bytes(bus.i_req_size);
    addr_end     = {1'b0, bus.i_req_addr} + (XLEN+1)'(req_bytes) - (XLEN+1)'(1);
    illegal      = (req_bytes == 3'd0);
    out_of_range = !illegal && (addr_end >= LimitBytes);
    misaligned   = ((bus.i_req_size == HWORD) && bus.i_req_addr[0]) ||
                   ((bus.i_req_size == WORD)  && (bus.i_req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
    req_err      = illegal | out_of_range;
`else
    req_err      = illegal | out_of_range | misaligned;
`endif
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic            split_q, split_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] asm_data;
  logic [1:0]      last_idx;
  logic [7:0]      wbyte;

  // Buffer with the current byte slot replaced by this cycle's memory byte
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      asm_data[8*i +: 8] = (cnt_q == 2'(i)) ? bus.i_mem_rdata[7:0] : buf_q[8*i +: 8];
    end
    last_idx = 2'(mem_op_bytes(req_q.size) - 3'd1);
    wbyte    = req_q.wdata[{cnt_q, 3'b000} +: 8];
    ext_in   = split_q ? asm_data : bus.i_mem_rdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      split_q <= 1'b0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      split_q <= split_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end
`else
  assign ext_in = bus.i_mem_rdata;
`endif

  load_extend u_load_extend (
    .data_i (ext_in),
    .size_i (req_q.size),
    .uns_i  (req_q.uns),
    .data_o (ext_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_err   = err_q;

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d         = split_q;
    cnt_d           = cnt_q;
    buf_d           = buf_q;
`endif
    bus.o_req_ready = 1'b0;
    bus.o_rsp_valid = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_re    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    bus.o_mem_size  = WORD;

    case (state_q)
      IDLE: begin
        bus.o_req_ready = 1'b1;
        if (bus.i_req_valid) begin
          req_d.we    = bus.i_req_we;
          req_d.addr  = bus.i_req_addr;
          req_d.wdata = bus.i_req_wdata;
          req_d.size  = bus.i_req_size;
          req_d.uns   = bus.i_req_unsigned;
          rdata_d     = '0;
          err_d       = req_err;
          state_d     = req_err ? RESP : ACCESS;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_d     = misaligned;
          cnt_d       = '0;
          buf_d       = '0;
`endif
        end
      end

      ACCESS: begin
        bus.o_mem_we    = req_q.we;
        bus.o_mem_re    = ~req_q.we;
        bus.o_mem_addr  = req_q.addr;
        bus.o_mem_wdata = req_q.wdata;
        bus.o_mem_size  = req_q.size;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_q) begin
          bus.o_mem_addr  = req_q.addr + XLEN'(cnt_q);
          bus.o_mem_wdata = XLEN'(wbyte);
          bus.o_mem_size  = BYTE;
          buf_d           = asm_data;
          if (cnt_q != last_idx) begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        if (!split_q || (cnt_q == last_idx)) begin
          rdata_d = req_q.we ? '0 : ext_data;
          state_d = RESP;
        end
`else
        rdata_d = req_q.we ? '0 : ext_data;
        state_d = RESP;
`endif
      end

      RESP: begin
        bus.o_rsp_valid = 1'b1;
        if (bus.i_rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a 16-byte little-endian memory model.
module tb_lsu_ctrl;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_clr = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.MemoryBytesSize(32'h4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [7:0]  mem [16];
  int unsigned re_cnt, we_cnt;

  function automatic int unsigned sz_bytes(mem_op_sz_e s);
    case (s)
      BYTE:    return 1;
      HWORD:   return 2;
      default: return 4;
    endcase
  endfunction

  always_comb begin
    bus.i_mem_rdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < sz_bytes(bus.o_mem_size))
        bus.i_mem_rdata[8*i +: 8] = mem[bus.o_mem_addr[3:0] + 4'(i)];
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      re_cnt <= 0;
      we_cnt <= 0;
    end else begin
      if (bus.o_mem_we) begin
        for (int unsigned i = 0; i < 4; i++)
          if (i < sz_bytes(bus.o_mem_size))
            mem[bus.o_mem_addr[3:0] + 4'(i)] <= bus.o_mem_wdata[8*i +: 8];
        we_cnt <= we_cnt + 1;
      end
      if (bus.o_mem_re) re_cnt <= re_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request in IDLE; returns 1 ns after the accepting edge
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input mem_op_sz_e sz, input logic uns);
    check("req_ready", 32'(bus.o_req_ready), 32'd1);
    bus.i_req_valid    = 1'b1;
    bus.i_req_we       = we;
    bus.i_req_addr     = a;
    bus.i_req_wdata    = wd;
    bus.i_req_size     = sz;
    bus.i_req_unsigned = uns;
    @(posedge clk); #1;
    bus.i_req_valid    = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.o_rsp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(posedge clk); #1;
    check("ready_after", 32'(bus.o_req_ready), 32'd1);
    check("valid_drop", 32'(bus.o_rsp_valid), 32'd0);
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input mem_op_sz_e sz, input logic uns,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    int unsigned re0, we0;
    re0 = re_cnt;
    we0 = we_cnt;
    issue(we, a, wd, sz, uns);
    check({tag, "_mem_we"}, 32'(bus.o_mem_we), 32'(!exp_err && we));
    check({tag, "_mem_re"}, 32'(bus.o_mem_re), 32'(!exp_err && !we));
    if (!exp_err) begin
      check({tag, "_mem_addr"}, bus.o_mem_addr, a);
      check({tag, "_mem_size"}, 32'(bus.o_mem_size), 32'(sz));
      if (we) check({tag, "_mem_wdata"}, bus.o_mem_wdata, wd);
    end
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
    check({tag, "_rdata"}, bus.o_rsp_rdata, exp_rd);
    check({tag, "_err"}, 32'(bus.o_rsp_err), 32'(exp_err));
    consume();
    check({tag, "_re_cnt"}, 32'(re_cnt - re0), (exp_err || we) ? 32'd0 : 32'd1);
    check({tag, "_we_cnt"}, 32'(we_cnt - we0), (!exp_err && we) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int unsigned re0;
    bus.i_req_valid    = 1'b0;
    bus.i_req_we       = 1'b0;
    bus.i_req_addr     = '0;
    bus.i_req_wdata    = '0;
    bus.i_req_size     = WORD;
    bus.i_req_unsigned = 1'b0;
    bus.i_rsp_ready    = 1'b1;

    #1 rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
    check("rst_mem_re", 32'(bus.o_mem_re), 32'd0);
    check("rst_mem_size", 32'(bus.o_mem_size), 32'(WORD));
    check("rst_mem_addr", bus.o_mem_addr, 32'd0);
    check("rst_rsp_rdata", bus.o_rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.o_rsp_err), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst     = 1'b0;
    mem_clr = 1'b0;

    // Basic store, then loads of every size/extension
    xact("st_w0",   1'b1, 32'h0, 32'hDEADBEEF, WORD,  1'b0, 32'h0,        1'b0);
    xact("ld_b3s",  1'b0, 32'h3, 32'h0,        BYTE,  1'b0, 32'hFFFFFFDE, 1'b0);
    xact("ld_h2u",  1'b0, 32'h2, 32'h0,        HWORD, 1'b1, 32'h0000DEAD, 1'b0);
    xact("ld_h2s",  1'b0, 32'h2, 32'h0,        HWORD, 1'b0, 32'hFFFFDEAD, 1'b0);
    xact("ld_b0u",  1'b0, 32'h0, 32'h0,        BYTE,  1'b1, 32'h000000EF, 1'b0);
    xact("ld_b0s",  1'b0, 32'h0, 32'h0,        BYTE,  1'b0, 32'hFFFFFFEF, 1'b0);
    xact("ld_h0s",  1'b0, 32'h0, 32'h0,        HWORD, 1'b0, 32'hFFFFBEEF, 1'b0);
    xact("ld_w0",   1'b0, 32'h0, 32'h0,        WORD,  1'b1, 32'hDEADBEEF, 1'b0);
    xact("ld_b1u",  1'b0, 32'h1, 32'h0,        BYTE,  1'b1, 32'h000000BE, 1'b0);

    // Last legal byte/halfword of the memory
    xact("st_bF",   1'b1, 32'hF, 32'h12345680, BYTE,  1'b0, 32'h0,        1'b0);
    xact("ld_bFs",  1'b0, 32'hF, 32'h0,        BYTE,  1'b0, 32'hFFFFFF80, 1'b0);
    xact("ld_hEu",  1'b0, 32'hE, 32'h0,        HWORD, 1'b1, 32'h00008000, 1'b0);

    // Out of range, wrap-around and illegal size
    xact("ld_wE",   1'b0, 32'hE,        32'h0, WORD, 1'b0, 32'h0, 1'b1);
    xact("ld_bFF",  1'b0, 32'hFFFFFFFF, 32'h0, BYTE, 1'b0, 32'h0, 1'b1);
    xact("ld_wFC",  1'b0, 32'hFFFFFFFC, 32'h0, WORD, 1'b0, 32'h0, 1'b1);
    xact("ld_b10",  1'b0, 32'h10,       32'h0, BYTE, 1'b0, 32'h0, 1'b1);
    xact("st_w10",  1'b1, 32'h10, 32'h11111111, WORD, 1'b0, 32'h0, 1'b1);
    xact("ld_ill",  1'b0, 32'h0,  32'h0, mem_op_sz_e'(2'd3), 1'b0, 32'h0, 1'b1);

`ifdef LSU_MISALIGN_SPLIT_EN
    re0 = re_cnt;
    issue(1'b0, 32'h2, 32'h0, WORD, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("spl_re", 32'(bus.o_mem_re), 32'd1);
      check("spl_addr", bus.o_mem_addr, 32'(2 + k));
      check("spl_size", 32'(bus.o_mem_size), 32'(BYTE));
      check("spl_valid_early", 32'(bus.o_rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    check("spl_valid", 32'(bus.o_rsp_valid), 32'd1);
    check("spl_rdata", bus.o_rsp_rdata, 32'h0000DEAD);
    check("spl_err", 32'(bus.o_rsp_err), 32'd0);
    consume();
    check("spl_re_cnt", 32'(re_cnt - re0), 32'd4);
    issue(1'b0, 32'h1, 32'h0, HWORD, 1'b0);
    wait_rsp(lat);
    check("spl_h_lat", 32'(lat), 32'd3);
    check("spl_h_rdata", bus.o_rsp_rdata, 32'hFFFFADBE);
    consume();
`else
    xact("ld_w2_mis", 1'b0, 32'h2, 32'h0, WORD,  1'b0, 32'h0, 1'b1);
    xact("ld_h1_mis", 1'b0, 32'h1, 32'h0, HWORD, 1'b0, 32'h0, 1'b1);
    xact("st_w1_mis", 1'b1, 32'h1, 32'h55555555, WORD, 1'b0, 32'h0, 1'b1);
`endif

    // Response back-pressure
    bus.i_rsp_ready = 1'b0;
    issue(1'b0, 32'h0, 32'h0, WORD, 1'b0);
    wait_rsp(lat);
    check("stall_lat", 32'(lat), 32'd2);
    repeat (5) begin
      check("stall_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("stall_rdata", bus.o_rsp_rdata, 32'hDEADBEEF);
      check("stall_ready", 32'(bus.o_req_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("stall_valid_last", 32'(bus.o_rsp_valid), 32'd1);
    bus.i_rsp_ready = 1'b1;
    consume();

    // Reset in the middle of a store access
    issue(1'b1, 32'h4, 32'h12345678, WORD, 1'b0);
    check("rst_acc_we", 32'(bus.o_mem_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_acc_we_drop", 32'(bus.o_mem_we), 32'd0);
    check("rst_acc_ready", 32'(bus.o_req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      check("rst_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
      check("rst_idle_ready", 32'(bus.o_req_ready), 32'd1);
      @(posedge clk); #1;
    end
    xact("post_ld_w4", 1'b0, 32'h4, 32'h0, WORD, 1'b0, 32'h0,        1'b0);
    xact("post_ld_w0", 1'b0, 32'h0, 32'h0, WORD, 1'b0, 32'hDEADBEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
